// File: rtl/apb_master_ctrl_pkg.sv
// Shared constants for the APB master controller: default bus widths,
// the default timeout and the FSM state encodings.
package apb_master_ctrl_pkg;

    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_TIMEOUT_CYCLES = 16;

    // FSM encodings, kept as plain constants so older tools can consume them
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;
    localparam logic [1:0] ST_GAP    = 2'b11;

    // Width of a counter able to hold the value n
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog: cleared on entry to ACCESS, counts every ACCESS
// cycle without PREADY and flags the cycle in which TIMEOUT_CYCLES is reached.
module apb_timeout_counter
    import apb_master_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAXV = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is flagged in the cycle whose increment would reach the limit
    assign expire_o = inc_i && (cnt_q == LAST);

    // Next count: clear wins, otherwise saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAXV)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-command APB master: each accepted command becomes one
// SETUP -> ACCESS transfer followed by a GAP cycle carrying the response.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic [ADDR_WIDTH-1:0] PADDR_m_s,
    output logic                  PWRITE_m_s,
    output logic                  PSEL_m_s,
    output logic                  PENABLE_m_s,
    output logic [DATA_WIDTH-1:0] PWDATA_m_s,
    input  logic                  PREADY_s_m,
    input  logic                  PSLVERR_s_m,
    input  logic [DATA_WIDTH-1:0] PRDATA_s_m
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  tmo_expire;
    logic                  accept;
    logic                  in_access;

    // Only IDLE takes commands; reset masks the handshake
    assign CMD_READY = (state_q == ST_IDLE) && !PRESET;
    assign accept    = (state_q == ST_IDLE) && CMD_VALID;
    assign in_access = (state_q == ST_ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
    logic rsp_tmo_q, rsp_tmo_d;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clr_i    (state_q == ST_SETUP),
        .inc_i    (in_access && !PREADY_s_m),
        .expire_o (tmo_expire)
    );

    // Timeout flag: set by expiry, cleared by a normal completion
    always_comb begin
        rsp_tmo_d = rsp_tmo_q;
        if (in_access) begin
            if (PREADY_s_m)      rsp_tmo_d = 1'b0;
            else if (tmo_expire) rsp_tmo_d = 1'b1;
        end
    end

    // Timeout flag register
    always_ff @(posedge PCLK) begin
        if (PRESET) rsp_tmo_q <= 1'b0;
        else        rsp_tmo_q <= rsp_tmo_d;
    end

    assign RSP_TIMEOUT = rsp_tmo_q;
`else
    assign tmo_expire  = 1'b0;
    assign RSP_TIMEOUT = 1'b0;
`endif

    // Next state: IDLE -> SETUP -> ACCESS (wait) -> GAP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (CMD_VALID) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY_s_m || tmo_expire) state_d = ST_GAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_GAP);
        if (accept) begin
            paddr_d  = CMD_ADDR;
            pwrite_d = CMD_WRITE;
            // Reads leave the last write data on the bus
            if (CMD_WRITE) pwdata_d = CMD_WDATA;
        end
        if (in_access) begin
            if (PREADY_s_m) begin
                rsp_err_d   = PSLVERR_s_m;
                rsp_rdata_d = (!pwrite_q && !PSLVERR_s_m) ? PRDATA_s_m : '0;
            end else if (tmo_expire) begin
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PADDR_m_s   = paddr_q;
    assign PWRITE_m_s  = pwrite_q;
    assign PSEL_m_s    = psel_q;
    assign PENABLE_m_s = penable_q;
    assign PWDATA_m_s  = pwdata_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl with a reactive APB slave and a
// transaction-level model of the expected response and timing.
module tb_apb_master_ctrl;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TCYC = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET, CMD_VALID, CMD_READY, CMD_WRITE;
    logic [AW-1:0] CMD_ADDR, PADDR;
    logic [DW-1:0] CMD_WDATA, RSP_RDATA, PWDATA, PRDATA;
    logic          RSP_VALID, RSP_ERR, RSP_TIMEOUT;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] pw_model = '0;

    typedef struct {
        int          k_rsp;
        int          psel_n;
        int          pen_n;
        bit          acc_ok;
        bit          held_ok;
        logic        rdy_after;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } obs_t;

    always #5 PCLK = ~PCLK;

    apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TCYC)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PADDR_m_s(PADDR), .PWRITE_m_s(PWRITE), .PSEL_m_s(PSEL),
        .PENABLE_m_s(PENABLE), .PWDATA_m_s(PWDATA),
        .PREADY_s_m(PREADY), .PSLVERR_s_m(PSLVERR), .PRDATA_s_m(PRDATA)
    );

    // Runs one command; the slave raises PREADY on ACCESS cycle waits+1.
    // k counts negedges after the accepting edge (k=1 is the SETUP cycle).
    task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit slverr, input logic [31:0] rdata,
                           output obs_t o);
        int k, acc;
        bit got;
        logic [31:0] exp_pw;
        o = '{k_rsp: -1, psel_n: 0, pen_n: 0, acc_ok: 1'b1, held_ok: 1'b0,
              rdy_after: 1'b0, rdata: '0, err: 1'b0, tmo: 1'b0};
        exp_pw = wr ? wdata : pw_model;
        @(negedge PCLK);
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
        k = 0;
        while (!CMD_READY && k < 20) begin @(negedge PCLK); k++; end
        if (!CMD_READY) begin CMD_VALID = 1'b0; return; end
        @(posedge PCLK); #1;
        CMD_VALID = 1'b0; CMD_ADDR = ~addr; CMD_WDATA = ~wdata; CMD_WRITE = ~wr;
        pw_model = exp_pw;
        acc = 0; got = 1'b0;
        for (k = 1; k <= waits + 40 && !got; k++) begin
            @(negedge PCLK);
            if (PSEL) o.psel_n++;
            if (PENABLE) o.pen_n++;
            if (PSEL && PENABLE) begin
                acc++;
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== exp_pw) o.acc_ok = 1'b0;
                PREADY  = (acc == waits + 1);
                PSLVERR = PREADY ? slverr : 1'($urandom);
                PRDATA  = PREADY ? rdata : $urandom;
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
            end
            if (RSP_VALID === 1'b1) begin
                got = 1'b1; o.k_rsp = k;
                o.rdata = RSP_RDATA; o.err = RSP_ERR; o.tmo = RSP_TIMEOUT;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        if (got) begin
            @(negedge PCLK);
            o.held_ok = (RSP_VALID === 1'b0) && (RSP_RDATA === o.rdata) &&
                        (RSP_ERR === o.err) && (RSP_TIMEOUT === o.tmo);
            o.rdy_after = CMD_READY;
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1; CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'hFFFF_FFFF;
        CMD_WDATA = 32'hFFFF_FFFF; PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
        repeat (3) @(negedge PCLK);
        n_cmp++;
        if ({CMD_READY, PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {CMD_READY, PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT});
        end
        n_cmp++;
        if (PADDR !== '0 || PWDATA !== '0 || RSP_RDATA !== '0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h/%h exp 0", PADDR, PWDATA, RSP_RDATA);
        end
        PRESET = 1'b0; CMD_VALID = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge PCLK);
        n_cmp++;
        if (CMD_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", CMD_READY); end
    endtask

    task automatic test_write();
        obs_t o;
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'hCAFE_F00D, o);
        n_cmp++;
        if (o.k_rsp !== 3) begin n_err++; $display("FAIL wr_latency got %0d exp 3", o.k_rsp); end
        n_cmp++;
        if (o.psel_n !== 2 || o.pen_n !== 1) begin
            n_err++; $display("FAIL wr_phases got psel %0d pen %0d exp 2/1", o.psel_n, o.pen_n);
        end
        n_cmp++;
        if (o.err !== 1'b0 || o.rdata !== 32'h0) begin
            n_err++; $display("FAIL wr_rsp got err %b rdata %h exp 0/0", o.err, o.rdata);
        end
        n_cmp++;
        if (!o.acc_ok) begin n_err++; $display("FAIL wr_bus got bad PADDR/PWRITE/PWDATA exp 10/1/deadbeef"); end
        n_cmp++;
        if (!o.held_ok || o.rdy_after !== 1'b1) begin
            n_err++; $display("FAIL wr_after got held %b ready %b exp 1/1", o.held_ok, o.rdy_after);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        do_xfer(1'b0, 32'h04, 32'h0, 5, 1'b0, 32'h12345678, o);
        n_cmp++;
        if (o.pen_n !== 6 || o.k_rsp !== 8) begin
            n_err++; $display("FAIL rd_wait got pen %0d lat %0d exp 6/8", o.pen_n, o.k_rsp);
        end
        n_cmp++;
        if (o.rdata !== 32'h12345678 || o.err !== 1'b0) begin
            n_err++; $display("FAIL rd_rsp got %h err %b exp 12345678/0", o.rdata, o.err);
        end
        n_cmp++;
        if (!o.acc_ok) begin n_err++; $display("FAIL rd_bus got PWDATA/addr changed exp held"); end
    endtask

    task automatic test_slverr();
        obs_t o;
        do_xfer(1'b0, 32'h20, 32'h0, 0, 1'b1, 32'hA5A5_A5A5, o);
        n_cmp++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.tmo !== 1'b0) begin
            n_err++; $display("FAIL slverr_rsp got err %b rdata %h tmo %b exp 1/0/0", o.err, o.rdata, o.tmo);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        int exp_k;
        do_xfer(1'b0, 32'h30, 32'h0, TCYC + 4, 1'b0, 32'h0BAD_F00D, o);
        exp_k = TMO_EN ? TCYC + 2 : TCYC + 7;
        n_cmp++;
        if (o.k_rsp !== exp_k || o.pen_n !== exp_k - 2) begin
            n_err++; $display("FAIL tmo_latency got %0d pen %0d exp %0d/%0d", o.k_rsp, o.pen_n, exp_k, exp_k - 2);
        end
        n_cmp++;
        if (o.err !== TMO_EN || o.tmo !== TMO_EN || o.rdata !== (TMO_EN ? 32'h0 : 32'h0BAD_F00D)) begin
            n_err++; $display("FAIL tmo_rsp got err %b tmo %b rdata %h exp %b/%b", o.err, o.tmo, o.rdata, TMO_EN, TMO_EN);
        end
        n_cmp++;
        if (o.rdy_after !== 1'b1) begin n_err++; $display("FAIL tmo_ready got %b exp 1", o.rdy_after); end
    endtask

    // Command held valid, slave always ready: a 4-cycle repeating pattern
    task automatic test_back_to_back();
        int bad_psel = 0, bad_pen = 0, bad_rsp = 0, bad_rdy = 0, bad_dat = 0, w = 0;
        logic [31:0] d;
        d = $urandom;
        @(negedge PCLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h44;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = d;
        while (!CMD_READY && w < 20) begin @(negedge PCLK); w++; end
        for (int k = 1; k <= 12; k++) begin
            @(negedge PCLK);
            if (PSEL !== (k % 4 == 1 || k % 4 == 2)) bad_psel++;
            if (PENABLE !== (k % 4 == 2)) bad_pen++;
            if (RSP_VALID !== (k % 4 == 3)) bad_rsp++;
            if (CMD_READY !== (k % 4 == 0)) bad_rdy++;
            if (k % 4 == 3 && (RSP_RDATA !== d || RSP_ERR !== 1'b0)) bad_dat++;
            if (k == 12) CMD_VALID = 1'b0;
        end
        PREADY = 1'b0;
        n_cmp++;
        if (bad_psel != 0 || bad_pen != 0) begin
            n_err++; $display("FAIL b2b_bus got %0d/%0d bad cycles exp 0", bad_psel, bad_pen);
        end
        n_cmp++;
        if (bad_rsp != 0 || bad_rdy != 0) begin
            n_err++; $display("FAIL b2b_handshake got %0d/%0d bad cycles exp 0", bad_rsp, bad_rdy);
        end
        n_cmp++;
        if (bad_dat != 0) begin n_err++; $display("FAIL b2b_data got %0d bad responses exp 0", bad_dat); end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid();
        int w = 0, rsp_seen = 0;
        obs_t o;
        @(negedge PCLK);
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h50; CMD_WDATA = 32'h1111_2222;
        while (!CMD_READY && w < 20) begin @(negedge PCLK); w++; end
        @(posedge PCLK); #1 CMD_VALID = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        n_cmp++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || RSP_VALID !== 1'b0 || PWDATA !== '0) begin
            n_err++; $display("FAIL midrst_bus got psel %b pen %b rsp %b pwdata %h exp 0", PSEL, PENABLE, RSP_VALID, PWDATA);
        end
        PRESET = 1'b0;
        pw_model = '0;
        @(negedge PCLK);
        n_cmp++;
        if (CMD_READY !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b exp 1", CMD_READY); end
        repeat (8) begin @(negedge PCLK); if (RSP_VALID !== 1'b0 || PSEL !== 1'b0) rsp_seen++; end
        n_cmp++;
        if (rsp_seen != 0) begin n_err++; $display("FAIL midrst_quiet got %0d active cycles exp 0", rsp_seen); end
        do_xfer(1'b0, 32'h54, 32'h0, 1, 1'b0, 32'h7777_8888, o);
        n_cmp++;
        if (o.k_rsp !== 4 || o.rdata !== 32'h7777_8888 || !o.acc_ok) begin
            n_err++; $display("FAIL midrst_recover got lat %0d rdata %h exp 4/77778888", o.k_rsp, o.rdata);
        end
    endtask

    task automatic test_random();
        obs_t o;
        bit wr, se, exp_tmo, exp_err;
        int waits, exp_k;
        logic [31:0] a, wd, rd, exp_rd;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom); se = ($urandom_range(0, 3) == 0);
            a = $urandom; wd = $urandom; rd = $urandom;
            waits = ($urandom_range(0, 7) == 0) ? TCYC - 1 + $urandom_range(0, 2) : $urandom_range(0, 5);
            do_xfer(wr, a, wd, waits, se, rd, o);
            exp_tmo = TMO_EN && (waits >= TCYC);
            exp_err = exp_tmo || se;
            exp_k   = exp_tmo ? TCYC + 2 : waits + 3;
            exp_rd  = (wr || exp_err) ? 32'h0 : rd;
            n_cmp++;
            if (o.k_rsp !== exp_k || o.psel_n !== exp_k - 1 || o.pen_n !== exp_k - 2) begin
                n_err++; $display("FAIL rnd%0d_timing got %0d/%0d/%0d exp %0d/%0d/%0d", i,
                                  o.k_rsp, o.psel_n, o.pen_n, exp_k, exp_k - 1, exp_k - 2);
            end
            n_cmp++;
            if (o.rdata !== exp_rd || o.err !== exp_err || o.tmo !== exp_tmo) begin
                n_err++; $display("FAIL rnd%0d_rsp got %h/%b/%b exp %h/%b/%b", i,
                                  o.rdata, o.err, o.tmo, exp_rd, exp_err, exp_tmo);
            end
            n_cmp++;
            if (!o.acc_ok || !o.held_ok || o.rdy_after !== 1'b1) begin
                n_err++; $display("FAIL rnd%0d_bus got acc %b held %b rdy %b exp 1/1/1", i,
                                  o.acc_ok, o.held_ok, o.rdy_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
